// File: rtl/test_dpram.sv
// Dual-port shared RAM: port A is a 32-bit byte-masked system bus port, port B a
// 128-bit line port for an accelerator. Both ports have one cycle of read latency.
module test_dpram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         wea,
    input  logic [3:0]   maska,
    input  logic [31:0]  addra,
    input  logic [31:0]  dina,
    output logic [31:0]  douta,
    input  logic         enb,
    input  logic         web,
    input  logic [31:0]  addrb,
    input  logic [127:0] dinb,
    output logic [127:0] doutb
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int LW = AW - 2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx_a_s;
    logic [LW-1:0] line_b_s;
    logic [31:0]   base_a_s;
    logic          unused_addr_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    assign idx_a_s       = addra[AW+1:2];
    assign line_b_s      = addrb[AW+1:4];
    assign unused_addr_s = ^{addra[31:AW+2], addra[1:0], addrb[31:AW+2], addrb[3:0]};

    // Port A merges onto port B's same-cycle data so that B keeps the bytes A masks out.
    always_comb begin
        base_a_s = mem[idx_a_s];
        if (enb && web && (line_b_s == idx_a_s[AW-1:2])) begin
            base_a_s = dinb[{idx_a_s[1:0], 5'd0} +: 32];
        end else begin
            base_a_s = mem[idx_a_s];
        end
    end

    // Storage update; port A is written last so it wins its enabled bytes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (enb && web) begin
                for (int w = 0; w < 4; w++) begin
                    mem[{line_b_s, 2'(w)}] <= dinb[32*w +: 32];
                end
            end
            if (ena && wea) begin
                mem[idx_a_s] <= merge_bytes(base_a_s, dina, maska);
            end
        end
    end

    // Port A read register; holds on idle and write cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta <= 32'd0;
        end else if (ena && !wea) begin
            douta <= mem[idx_a_s];
        end
    end

    // Port B line read register; holds on idle and write cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= 128'd0;
        end else if (enb && !web) begin
            doutb <= {mem[{line_b_s, 2'd3}], mem[{line_b_s, 2'd2}],
                      mem[{line_b_s, 2'd1}], mem[{line_b_s, 2'd0}]};
        end
    end

endmodule

// File: tb/tb_test_dpram.sv
// Directed and randomized bench for test_dpram against a byte-array reference model.
module tb_test_dpram;

    localparam int DW = 1024;
    localparam int NB = DW * 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
    logic [3:0]   maska = 4'd0;
    logic [31:0]  addra = 32'd0, dina = 32'd0, addrb = 32'd0;
    logic [127:0] dinb = 128'd0;
    logic [31:0]  douta;
    logic [127:0] doutb;

    logic [7:0]   rmem [NB];
    logic [31:0]  exp_a = 32'd0;
    logic [127:0] exp_b = 128'd0;
    int           errors = 0;
    int           checks = 0;
    logic [31:0]  held_a;
    logic [127:0] held_b;
    logic [31:0]  wq [$];

    test_dpram #(.DEPTH_WORDS(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .maska(maska), .addra(addra), .dina(dina), .douta(douta),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
    );

    always #5 clk = ~clk;

    function automatic int unsigned byte_base(input logic [31:0] addr, input int unsigned align);
        return (addr % 32'(NB)) & ~(align - 1);
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] addr);
        int unsigned b = byte_base(addr, 4);
        return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    endfunction

    function automatic logic [127:0] m_line(input logic [31:0] addr);
        logic [127:0] r;
        int unsigned b = byte_base(addr, 16);
        for (int i = 0; i < 16; i++) r[8*i +: 8] = rmem[b+i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock of both ports; the model reads old data first, then B writes, then A overrides.
    task automatic step(input logic ea, input logic wa, input logic [3:0] ma,
                        input logic [31:0] aa, input logic [31:0] da,
                        input logic eb, input logic wb, input logic [31:0] ab,
                        input logic [127:0] db);
        ena = ea; wea = wa; maska = ma; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        @(posedge clk);
        if (rst_n) begin
            if (ea && !wa) exp_a = m_word(aa);
            if (eb && !wb) exp_b = m_line(ab);
            if (eb && wb) begin
                for (int i = 0; i < 16; i++) rmem[byte_base(ab, 16) + i] = db[8*i +: 8];
            end
            if (ea && wa) begin
                for (int i = 0; i < 4; i++)
                    if (ma[i]) rmem[byte_base(aa, 4) + i] = da[8*i +: 8];
            end
        end else begin
            exp_a = 32'd0;
            exp_b = 128'd0;
        end
        #1;
        ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
    endtask

    task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        step(1'b1, 1'b1, m, a, d, 1'b0, 1'b0, 32'd0, 128'd0);
    endtask

    task automatic rd_a(input logic [31:0] a);
        step(1'b1, 1'b0, 4'd0, a, 32'd0, 1'b0, 1'b0, 32'd0, 128'd0);
    endtask

    initial begin
        logic [31:0] ra, rd;
        #2;
        chk("reset_douta", {96'd0, douta}, 128'd0);
        chk("reset_doutb", doutb, 128'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        wr_a(32'h10, 32'hDEADBEEF, 4'b1111);
        rd_a(32'h10);
        chk("full_word_rd", {96'd0, douta}, {96'd0, 32'hDEADBEEF});
        rd_a(32'h13);
        chk("unaligned_rd", {96'd0, douta}, {96'd0, 32'hDEADBEEF});
        held_a = douta;
        wr_a(32'h14, 32'h01020304, 4'b1111);
        chk("hold_on_a_write", {96'd0, douta}, {96'd0, held_a});

        wr_a(32'h20, 32'h11223344, 4'b1111);
        wr_a(32'h20, 32'hAABBCCDD, 4'b0101);
        wr_a(32'h20, 32'h99999999, 4'b0000);
        rd_a(32'h20);
        chk("byte_mask", {96'd0, douta}, {96'd0, 32'h11BB33DD});

        for (int i = 0; i < 4; i++) wr_a(32'h40 + 32'(4*i), 32'(i), 4'b1111);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h40, 128'd0);
        chk("cross_b_read", doutb, 128'h00000003_00000002_00000001_00000000);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h40,
             128'h44444444_33333333_22222222_11111111);
        rd_a(32'h48);
        chk("cross_a_read", {96'd0, douta}, {96'd0, 32'h33333333});

        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h50,
             128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
        step(1'b1, 1'b1, 4'b0011, 32'h50, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h50, {4{32'h12345678}});
        rd_a(32'h50);
        chk("collision_word", {96'd0, douta}, {96'd0, 32'h1234FFFF});
        step(1'b1, 1'b1, 4'b1111, 32'h50, 32'h0BAD0BAD, 1'b1, 1'b0, 32'h50, 128'd0);
        chk("b_read_old", doutb, {32'h12345678, 32'h12345678, 32'h12345678, 32'h1234FFFF});
        step(1'b1, 1'b0, 4'd0, 32'h54, 32'd0, 1'b1, 1'b1, 32'h50, {4{32'h77777777}});
        chk("a_read_old", {96'd0, douta}, {96'd0, 32'h12345678});
        held_a = douta; held_b = doutb;
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 128'd0);
        chk("hold_idle_a", {96'd0, douta}, {96'd0, held_a});
        chk("hold_idle_b", doutb, held_b);

        wr_a(32'(DW*4 + 8), 32'h5A5A1234, 4'b1111);
        rd_a(32'h8);
        chk("wrap_a", {96'd0, douta}, {96'd0, 32'h5A5A1234});
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'(DW*4 + 'h40), 128'd0);
        chk("wrap_b", doutb, 128'h44444444_33333333_22222222_11111111);

        rd_a(32'h10);
        #2; rst_n = 1'b0; exp_a = 32'd0; exp_b = 128'd0;
        #1;
        chk("async_rst_a", {96'd0, douta}, 128'd0);
        chk("async_rst_b", doutb, 128'd0);
        step(1'b1, 1'b1, 4'b1111, 32'h10, 32'h55555555, 1'b1, 1'b0, 32'h40, 128'd0);
        chk("rst_hold_a", {96'd0, douta}, 128'd0);
        chk("rst_hold_b", doutb, 128'd0);
        #2; rst_n = 1'b1;
        rd_a(32'h10);
        chk("post_rst_mem", {96'd0, douta}, {96'd0, 32'hDEADBEEF});
        rd_a(32'h8);
        chk("post_rst_wrap", {96'd0, douta}, {96'd0, 32'h5A5A1234});

        for (int n = 0; n < 50; n++) begin
            ra = 32'($urandom_range(0, 500));
            rd = $urandom;
            wr_a(ra, rd, 4'b1111);
            wq.push_back(ra);
            rd_a(wq[$urandom_range(0, wq.size() - 1)]);
            chk("soak_read", {96'd0, douta}, {96'd0, exp_a});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
